cart_led_ctrl: RTL and testbench
================================

CART_LED_CTRL -- requirements
Module: cart_led_ctrl

Interface
REQ-001 SHALL have parameter CHANNELS, default 3: number of independent LED channels.
REQ-002 SHALL have parameter PRESCALE, default 1000: clock cycles per timebase tick, legal range 1 or more.
REQ-003 SHALL have parameter HOLD_TICKS, default 32: activity stretch length in ticks, legal range 1 to 2^CNT_WIDTH-1.
REQ-004 SHALL have parameter BLINK_TICKS, default 250: ticks per blink half-period, legal range 1 to 2^CNT_WIDTH-1.
REQ-005 SHALL have parameter CNT_WIDTH, default 8: width of the hold and blink counters.
REQ-006 SHALL have parameter PWM_WIDTH, default 4: width of the brightness value.
REQ-007 SHALL have port i_clk  input  1: single clock.
REQ-008 SHALL have port i_reset  input  1: reset, asynchronous and active-high.
REQ-009 SHALL have port i_trigger  input  CHANNELS: per-channel activity pulse, level-sampled every clock.
REQ-010 SHALL have port i_mode  input  2*CHANNELS: per-channel mode, bits [2n+1:2n] belong to channel n.
REQ-011 SHALL have port i_brightness  input  PWM_WIDTH: global duty value.
REQ-012 SHALL have port o_led  output  CHANNELS: registered LED drive, 1 = lit.

Function
REQ-013 SHALL decode the modes as: 0 = OFF (raw 0), 1 = ON (raw 1), 2 = ACTIVITY (raw = hold counter nonzero), 3 = BLINK (raw = blink phase).
REQ-014 SHALL run a prescaler that counts 0 to PRESCALE-1 and wraps, asserting a one-cycle tick when the count equals PRESCALE-1; with PRESCALE=1, tick SHALL be high every cycle.
REQ-015 SHALL give each channel a hold counter for ACTIVITY mode, updated in this order: trigger high loads HOLD_TICKS; otherwise, on a tick with the counter nonzero, the counter decrements; otherwise it holds.
REQ-016 SHALL give trigger priority over a tick when both occur in the same cycle (retrigger extends, never shortens).
REQ-017 SHALL hold a channel's hold counter at 0 whenever its mode is not ACTIVITY; a trigger in a non-ACTIVITY mode SHALL be ignored.
REQ-018 SHALL run one shared blink counter that counts ticks 0 to BLINK_TICKS-1 and wraps; the shared blink phase SHALL toggle on each wrap, so all BLINK channels are in phase.
REQ-019 SHALL run a free-running PWM counter of PWM_WIDTH bits, incrementing every clock; gate = 1 when i_brightness is all-ones, otherwise gate = (PWM counter < i_brightness); i_brightness = 0 keeps all LEDs dark.
REQ-020 SHALL register o_led[n] = raw[n] AND gate; the latency from the cycle raw changes to the o_led change SHALL be one clock.
REQ-021 SHALL make a trigger in cycle t visible on o_led in cycle t+2, given an all-ones i_brightness (one cycle to load the counter, one output register).
REQ-022 SHALL give ACTIVITY lit duration after a last trigger of HOLD_TICKS ticks minus the phase of the current tick, in the range (HOLD_TICKS-1)*PRESCALE+1 to HOLD_TICKS*PRESCALE cycles.
REQ-023 SHALL take effect on a mode change in the next cycle; leaving ACTIVITY SHALL clear the hold counter, and entering BLINK SHALL adopt the current shared phase.

Reset
REQ-024 SHALL, on asserting i_reset, asynchronously clear the prescaler, all hold counters, the blink counter, the blink phase, the PWM counter and o_led to 0.
REQ-025 SHALL ignore a trigger that coincides with reset; on deassertion the block SHALL start from the all-zero state, and the first tick SHALL occur PRESCALE cycles later.

Structure
REQ-026 SHALL define the mode encodings (OFF, ON, ACTIVITY, BLINK) as constants in the shared package cart_led_pkg.
REQ-027 SHALL place the per-channel hold counter and mode mux in sub-module cart_led_channel, instantiated CHANNELS times; the prescaler, blink and PWM logic SHALL be shared in the top module.

Verification
REQ-028 SHALL cover: PRESCALE=4, HOLD_TICKS=3, brightness all-ones, one trigger on ch0 in ACTIVITY -> o_led[0] rises 2 cycles later and falls after 9 to 12 cycles lit.
REQ-029 SHALL cover: a retrigger on ch0 on the same cycle as a tick, with the counter at 1 -> the counter reloads to 3 and the LED never drops.
REQ-030 SHALL cover: BLINK_TICKS=2, PRESCALE=4, ch1 and ch2 both in BLINK -> both toggle together every 8 cycles.
REQ-031 SHALL cover: PWM_WIDTH=4, ch0 ON, brightness=4 -> o_led[0] high 4 of every 16 cycles; brightness=0 -> always low; brightness=15 -> always high.
REQ-032 SHALL cover: ch0 in ACTIVITY, lit, mode switched to OFF -> the LED goes low 1 cycle later; a trigger while OFF -> no output.
REQ-033 SHALL cover: reset asserted mid-hold, asynchronously between clock edges -> o_led goes 0 immediately and all counters read 0 after release.

Source files
------------

// File: rtl/cart_led_pkg.sv
// Shared definitions for the cart LED controller: per-channel mode encodings
// and a small helper that turns raw mode bits into the typed mode.
package cart_led_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF      = 2'd0,
        MODE_ON       = 2'd1,
        MODE_ACTIVITY = 2'd2,
        MODE_BLINK    = 2'd3
    } mode_e;

    // Every 2-bit pattern is a legal mode, so a plain cast is safe.
    function automatic mode_e decode_mode(input logic [MODE_W-1:0] bits);
        return mode_e'(bits);
    endfunction

endpackage

// File: rtl/cart_led_if.sv
// Pin-level bundle of the LED controller: per-channel triggers and modes,
// global brightness, and the LED drive coming back. The master side drives
// the controls and observes the LEDs; the slave side is the controller.
interface cart_led_if #(
    parameter int CHANNELS  = 3,
    parameter int PWM_WIDTH = 4
);
    logic [CHANNELS-1:0]   trigger;
    logic [2*CHANNELS-1:0] mode;
    logic [PWM_WIDTH-1:0]  brightness;
    logic [CHANNELS-1:0]   led;

    modport master (output trigger, output mode, output brightness, input led);
    modport slave  (input trigger, input mode, input brightness, output led);
endinterface

// File: rtl/cart_led_channel.sv
// One LED channel: the activity hold counter plus the mode multiplexer that
// produces the unregistered "raw" lit request for this channel.
module cart_led_channel
    import cart_led_pkg::*;
#(
    parameter int HOLD_TICKS = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_trigger,
    input  logic [MODE_W-1:0] i_mode,
    input  logic              i_tick,
    input  logic              i_blink_phase,
    output logic              o_raw
);

    mode_e                w_mode;
    logic [CNT_WIDTH-1:0] r_hold;

    assign w_mode = decode_mode(i_mode);

    // Hold counter: a trigger reloads (and wins over a coincident tick, so a
    // retrigger only ever extends); ticks count down to zero; any mode other
    // than ACTIVITY keeps it cleared so triggers there are ignored.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_hold <= '0;
        end else if (w_mode != MODE_ACTIVITY) begin
            r_hold <= '0;
        end else if (i_trigger) begin
            r_hold <= CNT_WIDTH'(HOLD_TICKS);
        end else if (i_tick && (r_hold != '0)) begin
            r_hold <= r_hold - CNT_WIDTH'(1);
        end
    end

    // Mode mux: select what this channel wants to show right now.
    always_comb begin
        o_raw = 1'b0;
        case (w_mode)
            MODE_OFF:      o_raw = 1'b0;
            MODE_ON:       o_raw = 1'b1;
            MODE_ACTIVITY: o_raw = (r_hold != '0);
            MODE_BLINK:    o_raw = i_blink_phase;
            default:       o_raw = 1'b0;
        endcase
    end

endmodule

// File: rtl/cart_led_ctrl.sv
// Multi-channel LED controller. Shared timebase (prescaler tick), shared
// blink phase and shared PWM brightness gate live here; each channel's hold
// counter and mode mux live in cart_led_channel. The LED outputs are
// registered, so a raw change shows on o_led one clock later.
module cart_led_ctrl
    import cart_led_pkg::*;
#(
    parameter int CHANNELS    = 3,
    parameter int PRESCALE    = 1000,
    parameter int HOLD_TICKS  = 32,
    parameter int BLINK_TICKS = 250,
    parameter int CNT_WIDTH   = 8,
    parameter int PWM_WIDTH   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [CHANNELS-1:0]   i_trigger,
    input  logic [2*CHANNELS-1:0] i_mode,
    input  logic [PWM_WIDTH-1:0]  i_brightness,
    output logic [CHANNELS-1:0]   o_led
);

    // A prescale of 1 still needs a 1-bit counter; it simply stays at 0 and
    // the tick is then high every cycle.
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0]      r_presc;
    logic                 w_tick;
    logic [CNT_WIDTH-1:0] r_blink_cnt;
    logic                 r_blink_phase;
    logic                 w_blink_wrap;
    logic [PWM_WIDTH-1:0] r_pwm_cnt;
    logic                 w_gate;
    logic [CHANNELS-1:0]  w_raw;
    logic [CHANNELS-1:0]  r_led;

    assign w_tick       = (r_presc == PS_W'(PRESCALE - 1));
    assign w_blink_wrap = (r_blink_cnt == CNT_WIDTH'(BLINK_TICKS - 1));

    // Full-scale brightness must be solidly on, which a plain compare against
    // a wrapping counter cannot give, hence the all-ones override.
    assign w_gate = (&i_brightness) | (r_pwm_cnt < i_brightness);

    // Prescaler: count 0..PRESCALE-1 and wrap on the tick cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PS_W'(1);
        end
    end

    // Shared blink: count ticks, flip the phase on each wrap so every BLINK
    // channel lights in step.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_tick) begin
            if (w_blink_wrap) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Free-running PWM counter driving the brightness gate.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_WIDTH'(1);
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        cart_led_channel #(
            .HOLD_TICKS (HOLD_TICKS),
            .CNT_WIDTH  (CNT_WIDTH)
        ) u_ch (
            .i_clk         (i_clk),
            .i_reset       (i_reset),
            .i_trigger     (i_trigger[g]),
            .i_mode        (i_mode[2*g +: MODE_W]),
            .i_tick        (w_tick),
            .i_blink_phase (r_blink_phase),
            .o_raw         (w_raw[g])
        );
    end

    // Output register: raw request gated by the shared brightness PWM.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_led <= '0;
        end else begin
            r_led <= w_raw & {CHANNELS{w_gate}};
        end
    end

    assign o_led = r_led;

endmodule

// File: tb/tb_cart_led_ctrl.sv
// Self-checking bench for cart_led_ctrl with a small configuration
// (PRESCALE=4, HOLD_TICKS=3, BLINK_TICKS=2, PWM_WIDTH=4). A cycle-counting
// model derives every expected LED value from elapsed time; directed
// scenarios add literal expectations on top.
`timescale 1ns/1ps
module tb_cart_led_ctrl;

    localparam int CH      = 3;
    localparam int P       = 4;
    localparam int HOLD    = 3;
    localparam int BLINK   = 2;
    localparam int CW      = 8;
    localparam int PW      = 4;
    localparam int TIMEOUT = 100;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cart_led_if #(.CHANNELS(CH), .PWM_WIDTH(PW)) bus ();

    cart_led_ctrl #(
        .CHANNELS    (CH),
        .PRESCALE    (P),
        .HOLD_TICKS  (HOLD),
        .BLINK_TICKS (BLINK),
        .CNT_WIDTH   (CW),
        .PWM_WIDTH   (PW)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_trigger    (bus.trigger),
        .i_mode       (bus.mode),
        .i_brightness (bus.brightness),
        .o_led        (bus.led)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // n is the index of the current cycle since reset release. Ticks land on
    // cycles with n%P == P-1, so ticks completed before cycle n is n/P; the
    // blink phase is how many whole BLINK groups of ticks have elapsed, mod 2.
    // An activity channel stays lit while fewer than HOLD ticks have passed
    // since its last trigger.
    logic [CH-1:0] exp_q[$];
    int n;
    int since [CH];
    bit armed [CH];

    task automatic model_clear();
        n = 0;
        for (int c = 0; c < CH; c++) begin
            since[c] = 0;
            armed[c] = 1'b0;
        end
        exp_q.delete();
        exp_q.push_back('0);
    endtask

    task automatic model_step();
        logic [CH-1:0] exp;
        bit tick;
        bit gate;
        int phase;
        int pwm;
        int br;
        exp   = '0;
        tick  = ((n % P) == P - 1);
        phase = ((n / P) / BLINK) % 2;
        pwm   = n % (1 << PW);
        br    = int'(bus.brightness);
        gate  = (br == (1 << PW) - 1) || (pwm < br);
        for (int c = 0; c < CH; c++) begin
            int m;
            bit raw;
            m = int'(bus.mode[2*c +: 2]);
            case (m)
                0:       raw = 1'b0;
                1:       raw = 1'b1;
                2:       raw = armed[c] && (since[c] < HOLD);
                default: raw = (phase == 1);
            endcase
            exp[c] = raw && gate;
            if (m == 2) begin
                if (bus.trigger[c]) begin
                    armed[c] = 1'b1;
                    since[c] = 0;
                end else if (tick && armed[c] && since[c] < HOLD) begin
                    since[c] = since[c] + 1;
                end
            end else begin
                armed[c] = 1'b0;
                since[c] = 0;
            end
        end
        exp_q.push_back(exp);
        n = n + 1;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_clear();
            else     model_step();
        end
    end

    // ---------------- scoreboard compare ----------------
    initial begin
        logic [CH-1:0] exp;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (bus.led !== exp) begin
                    n_fail++;
                    $display("FAIL model_led cycle=%0d actual=%b expected=%b", n, bus.led, exp);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_trigger(input int ch);
        @(negedge clk);
        bus.trigger[ch] = 1'b1;
        @(negedge clk);
        bus.trigger[ch] = 1'b0;
    endtask

    task automatic count_led_high(input int ch, input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.led[ch]) cnt++;
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int lit;
        int cnt;
        int guard;
        bit found;
        bit low_seen;
        int changes[$];
        logic prev;

        bus.trigger    = '0;
        bus.mode       = '0;
        bus.brightness = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_led", 32'(bus.led), 0);
        check("reset_presc", 32'(dut.r_presc), 0);
        rst = 1'b0;

        // Single activity trigger on ch0.
        bus.brightness = 4'hF;
        bus.mode       = 6'b000010;
        pulse_trigger(0);
        check("act_not_yet_t1", 32'(bus.led[0]), 0);
        @(negedge clk);
        check("act_rise_t2", 32'(bus.led[0]), 1);
        lit   = 1;
        guard = 0;
        while (bus.led[0] && guard < TIMEOUT) begin
            @(negedge clk);
            guard++;
            if (bus.led[0]) lit++;
        end
        check("act_lit_9_to_12", 32'((lit >= 9 && lit <= 12) ? 1 : 0), 1);

        // Retrigger on a tick cycle with the counter at 1.
        pulse_trigger(0);
        found = 1'b0;
        for (int i = 0; i < TIMEOUT && !found; i++) begin
            if (since[0] == HOLD - 1 && (n % P) == P - 1) found = 1'b1;
            else @(negedge clk);
        end
        check("retrig_found", 32'(found), 1);
        check("retrig_hold_pre", 32'(dut.g_ch[0].u_ch.r_hold), 1);
        bus.trigger[0] = 1'b1;
        @(negedge clk);
        bus.trigger[0] = 1'b0;
        check("retrig_hold_reload", 32'(dut.g_ch[0].u_ch.r_hold), 3);
        low_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (!bus.led[0]) low_seen = 1'b1;
            @(negedge clk);
        end
        check("retrig_no_drop", 32'(low_seen), 0);

        // Blink on ch1 and ch2: in phase, toggling every BLINK*P cycles.
        bus.mode = 6'b111100;
        prev     = bus.led[1];
        low_seen = 1'b0;
        for (int i = 0; i < 60 && changes.size() < 5; i++) begin
            @(negedge clk);
            if (bus.led[1] !== bus.led[2]) low_seen = 1'b1;
            if (bus.led[1] !== prev) changes.push_back(i);
            prev = bus.led[1];
        end
        check("blink_in_phase", 32'(low_seen), 0);
        check("blink_changes", 32'(changes.size()), 5);
        if (changes.size() == 5) begin
            for (int k = 1; k < 4; k++)
                check("blink_period", 32'(changes[k+1] - changes[k]), 8);
        end

        // PWM brightness on ch0 held ON.
        bus.mode       = 6'b000001;
        bus.brightness = 4'd4;
        count_led_high(0, 16, cnt);
        check("pwm_b4", 32'(cnt), 4);
        bus.brightness = 4'd0;
        count_led_high(0, 16, cnt);
        check("pwm_b0", 32'(cnt), 0);
        bus.brightness = 4'd15;
        count_led_high(0, 16, cnt);
        check("pwm_b15", 32'(cnt), 16);

        // Leave ACTIVITY while lit; triggers in OFF do nothing.
        bus.mode = 6'b000010;
        pulse_trigger(0);
        @(negedge clk);
        check("off_pre_lit", 32'(bus.led[0]), 1);
        bus.mode = 6'b000000;
        @(negedge clk);
        check("off_drop_1cyc", 32'(bus.led[0]), 0);
        check("off_hold_clr", 32'(dut.g_ch[0].u_ch.r_hold), 0);
        pulse_trigger(0);
        count_led_high(0, 4, cnt);
        check("off_trig_led", 32'(cnt), 0);
        check("off_trig_hold", 32'(dut.g_ch[0].u_ch.r_hold), 0);

        // Asynchronous reset mid-hold, with a coincident trigger.
        bus.mode = 6'b000010;
        pulse_trigger(0);
        @(negedge clk);
        check("rst_pre_lit", 32'(bus.led[0]), 1);
        @(posedge clk);
        #2;
        rst            = 1'b1;
        bus.trigger[0] = 1'b1;
        #1;
        check("rst_async_led", 32'(bus.led), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst            = 1'b0;
        bus.trigger[0] = 1'b0;
        check("rst_presc", 32'(dut.r_presc), 0);
        check("rst_blink_cnt", 32'(dut.r_blink_cnt), 0);
        check("rst_blink_phase", 32'(dut.r_blink_phase), 0);
        check("rst_pwm_cnt", 32'(dut.r_pwm_cnt), 0);
        check("rst_holds", 32'(dut.g_ch[0].u_ch.r_hold) + 32'(dut.g_ch[1].u_ch.r_hold)
                           + 32'(dut.g_ch[2].u_ch.r_hold), 0);
        repeat (3) @(negedge clk);
        check("first_tick_presc", 32'(dut.r_presc), 3);
        check("rst_trig_ignored", 32'(dut.g_ch[0].u_ch.r_hold), 0);
        @(negedge clk);
        check("first_tick_wrap", 32'(dut.r_presc), 0);
        check("first_tick_blink", 32'(dut.r_blink_cnt), 1);
        check("post_rst_led", 32'(bus.led), 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Hard stop if something hangs.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
